// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset PC, major opcodes and the
// fetch-buffer entry type used between fetch and decode.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush empties it and wins over push/pop;
// push while full is accepted when a pop happens in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push) wr_d = wr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word reads, buffers responses and
// hands {instr, pc, pc+4} to decode. Redirects flush everything and discard stale reads.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   disc_q, disc_d;

    logic [XLEN-1:0] sq_mem_q [FIFO_DEPTH];
    logic [AW-1:0]   sq_rd_q, sq_rd_d;
    logic [AW-1:0]   sq_wr_q, sq_wr_d;

    fetch_entry_t    fifo_head, fifo_in;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full, fifo_empty;
    logic            fifo_push;

    logic            fire, pop, rsp_drop;
    logic [CW:0]     occupancy;
    logic            unused_redirect_lsb;

    assign pop  = instr_valid & instr_ready;
    assign fire = imem_req_valid & imem_req_ready;

    // A slot drained by decode this cycle is free before any new response can land,
    // so it is credited straight back; this is what sustains one instruction per cycle.
    assign occupancy = {1'b0, out_q} + {1'b0, fifo_cnt} - (CW+1)'(pop);

    assign imem_req_valid = reset_n & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;

    // Stale reads from before a redirect, or one landing in the redirect cycle, are dropped.
    assign rsp_drop  = redirect_valid | (disc_q != '0);
    assign fifo_push = imem_rsp_valid & ~rsp_drop;
    assign fifo_in   = '{instr: imem_rsp_data, pc: sq_mem_q[sq_rd_q]};

    always_comb begin
        pc_d    = pc_q;
        out_d   = out_q + CW'(fire) - CW'(imem_rsp_valid);
        disc_d  = disc_q;
        sq_rd_d = sq_rd_q;
        sq_wr_d = sq_wr_q;

        if (fire)           sq_wr_d = sq_wr_q + AW'(1);
        if (imem_rsp_valid) sq_rd_d = sq_rd_q + AW'(1);

        if (redirect_valid) begin
            pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            disc_d = out_q - CW'(imem_rsp_valid);
        end else begin
            if (fire) pc_d = pc_plus4(pc_q);
            if (imem_rsp_valid && disc_q != '0) disc_d = disc_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            sq_rd_q <= '0;
            sq_wr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            sq_rd_q <= sq_rd_d;
            sq_wr_q <= sq_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) sq_mem_q[sq_wr_q] <= pc_q;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign instr_valid    = ~fifo_empty;
    assign instr          = fifo_head.instr;
    assign instr_pc       = fifo_head.pc;
    assign instr_pc_plus4 = pc_plus4(fifo_head.pc);

    assign unused_redirect_lsb = ^{redirect_pc[1:0], fifo_full};

    a_rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n) imem_rsp_valid |-> (out_q != '0));

endmodule
